// File: rtl/safe_controller_param.sv
// safe_controller_param: keypad safe FSM with password check, change-with-confirm and timed lockout
module safe_controller_param #(
  parameter int PW_LEN = 6,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW = 24'h123456
) (
  input  logic clk,
  input  logic reset,
  input  logic key_valid,
  input  logic [3:0] key_code,
  input  logic reset_password,
  input  logic initialize,
  output logic [PW_LEN-1:0] password_led,
  output logic [2:0] state,
  output logic unlocked,
  output logic error,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);
  localparam int FW = $clog2(MAX_TRIES+1);
  localparam int CW = $clog2(PW_LEN+1);
  localparam int TW = $clog2(LOCKOUT_CYCLES);
  localparam int BW = 4*PW_LEN;
  typedef enum logic [2:0] {LOCKED, ENTRY, OPEN, SET_NEW, CONFIRM, LOCKOUT} st_t;
  st_t st, st_n;
  logic [BW-1:0] ent, ent_n, tmp, tmp_n, pw, pw_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] fc_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [PW_LEN-1:0] led_n;
  logic err_n, dig, star, sharp, room, full;
  assign dig = key_valid && key_code <= 4'd9;
  assign star = key_valid && key_code == 4'd10;
  assign sharp = key_valid && key_code == 4'd11;
  assign room = cnt < CW'(PW_LEN);
  assign full = cnt == CW'(PW_LEN);
  assign state = st;
  // digits shift in from the right so digit 0 ends up in the MSBs after PW_LEN keys
  always_comb begin
    st_n = st;
    ent_n = ent;
    tmp_n = tmp;
    pw_n = pw;
    cnt_n = cnt;
    fc_n = fail_count;
    tmr_n = tmr;
    err_n = 1'b0;
    if (initialize && st != LOCKOUT) begin
      st_n = LOCKED;
      ent_n = '0;
      tmp_n = '0;
      pw_n = DEFAULT_PW;
      cnt_n = '0;
      fc_n = '0;
      tmr_n = '0;
    end else begin
      case (st)
        LOCKED: if (dig) begin
          st_n = ENTRY;
          ent_n = {{(BW-4){1'b0}}, key_code};
          cnt_n = CW'(1);
        end
        ENTRY: begin
          if (dig && room) begin
            ent_n = {ent[BW-5:0], key_code};
            cnt_n = cnt + 1'b1;
          end
          if (star || sharp) begin
            ent_n = '0;
            cnt_n = '0;
            st_n = LOCKED;
          end
          if (sharp && full && ent == pw) begin
            st_n = OPEN;
            fc_n = '0;
          end else if (sharp) begin
            err_n = 1'b1;
            fc_n = fail_count + 1'b1;
            if (fc_n == FW'(MAX_TRIES)) begin
              st_n = LOCKOUT;
              tmr_n = TW'(LOCKOUT_CYCLES-1);
            end
          end
        end
        OPEN: if (reset_password) begin
          st_n = SET_NEW;
          cnt_n = '0;
        end else if (sharp) st_n = LOCKED;
        SET_NEW, CONFIRM: begin
          if (dig && room) begin
            ent_n = {ent[BW-5:0], key_code};
            cnt_n = cnt + 1'b1;
          end
          if (star) begin
            st_n = OPEN;
            cnt_n = '0;
          end else if (sharp) begin
            cnt_n = '0;
            if (st == SET_NEW) begin
              tmp_n = full ? ent : tmp;
              st_n = full ? CONFIRM : SET_NEW;
              err_n = !full;
            end else begin
              st_n = OPEN;
              pw_n = (full && ent == tmp) ? ent : pw;
              err_n = !(full && ent == tmp);
            end
          end
        end
        LOCKOUT: begin
          tmr_n = tmr - 1'b1;
          if (tmr == '0) begin
            st_n = LOCKED;
            fc_n = '0;
            tmr_n = '0;
          end
        end
        default: st_n = LOCKED;
      endcase
    end
    led_n = st_n == OPEN ? '1 :
            (st_n == ENTRY || st_n == SET_NEW || st_n == CONFIRM) ? ~({PW_LEN{1'b1}} << cnt_n) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= LOCKED;
      ent <= '0;
      tmp <= '0;
      pw <= DEFAULT_PW;
      cnt <= '0;
      fail_count <= '0;
      tmr <= '0;
      password_led <= '0;
      unlocked <= 1'b0;
      error <= 1'b0;
    end else begin
      st <= st_n;
      ent <= ent_n;
      tmp <= tmp_n;
      pw <= pw_n;
      cnt <= cnt_n;
      fail_count <= fc_n;
      tmr <= tmr_n;
      password_led <= led_n;
      unlocked <= st_n == OPEN;
      error <= err_n;
    end
  end
endmodule

// File: tb/tb_safe_controller_param.sv
// tb_safe_controller_param: directed bench for the keypad safe controller
module tb_safe_controller_param;
  logic clk = 1'b0, reset = 1'b1, key_valid = 1'b0, reset_password = 1'b0, initialize = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [5:0] password_led;
  logic [2:0] state;
  logic unlocked, error;
  logic [1:0] fail_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  safe_controller_param dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .reset_password(reset_password), .initialize(initialize),
    .password_led(password_led), .state(state), .unlocked(unlocked),
    .error(error), .fail_count(fail_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic st3(input string tag, input logic [2:0] s, input logic [5:0] led, input logic ul);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".led"}, 32'(password_led), 32'(led));
    chk({tag, ".unlocked"}, 32'(unlocked), 32'(ul));
  endtask
  task automatic key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask
  task automatic pw(input logic [23:0] v);
    for (int i = 5; i >= 0; i--) key(v[4*i +: 4]);
    key(4'd11);
  endtask
  task automatic rp_pulse();
    @(negedge clk);
    reset_password = 1'b1;
    @(negedge clk);
    reset_password = 1'b0;
  endtask
  task automatic short_try();
    for (int i = 1; i <= 5; i++) key(4'(i));
    key(4'd11);
  endtask
  initial begin
    #12;
    st3("rst", 3'd0, 6'd0, 1'b0);
    chk("rst.err", 32'(error), 32'd0);
    chk("rst.fc", 32'(fail_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    key(4'd1);
    st3("first_digit", 3'd1, 6'b000001, 1'b0);
    for (int i = 2; i <= 6; i++) key(4'(i));
    st3("six_digits", 3'd1, 6'b111111, 1'b0);
    key(4'd11);
    st3("unlock", 3'd2, 6'b111111, 1'b1);
    key(4'd11);
    st3("relock", 3'd0, 6'd0, 1'b0);
    short_try();
    st3("fail1", 3'd0, 6'd0, 1'b0);
    chk("fail1.err", 32'(error), 32'd1);
    chk("fail1.fc", 32'(fail_count), 32'd1);
    @(negedge clk);
    chk("fail1.err_drop", 32'(error), 32'd0);
    short_try();
    chk("fail2.fc", 32'(fail_count), 32'd2);
    chk("fail2.state", 32'(state), 32'd0);
    short_try();
    chk("fail3.state", 32'(state), 32'd5);
    chk("fail3.fc", 32'(fail_count), 32'd3);
    chk("fail3.err", 32'(error), 32'd1);
    pw(24'h123456);
    rp_pulse();
    st3("lockout_keys", 3'd5, 6'd0, 1'b0);
    repeat (1000 - 1 - 16) @(negedge clk);
    chk("lockout_last.state", 32'(state), 32'd5);
    chk("lockout_last.fc", 32'(fail_count), 32'd3);
    @(negedge clk);
    chk("lockout_exit.state", 32'(state), 32'd0);
    chk("lockout_exit.fc", 32'(fail_count), 32'd0);
    pw(24'h123456);
    chk("unlock2", 32'(state), 32'd2);
    rp_pulse();
    st3("set_new", 3'd3, 6'd0, 1'b0);
    key(4'd1);
    key(4'd2);
    key(4'd11);
    st3("set_short", 3'd3, 6'd0, 1'b0);
    chk("set_short.err", 32'(error), 32'd1);
    pw(24'h987654);
    st3("confirm", 3'd4, 6'd0, 1'b0);
    pw(24'h987655);
    st3("confirm_bad", 3'd2, 6'b111111, 1'b1);
    chk("confirm_bad.err", 32'(error), 32'd1);
    key(4'd11);
    pw(24'h123456);
    chk("old_pw_kept", 32'(state), 32'd2);
    @(negedge clk);
    reset_password = 1'b1;
    @(negedge clk);
    chk("rp_held.set_new", 32'(state), 32'd3);
    pw(24'h987654);
    chk("rp_held.confirm", 32'(state), 32'd4);
    reset_password = 1'b0;
    pw(24'h987654);
    st3("changed", 3'd2, 6'b111111, 1'b1);
    chk("changed.err", 32'(error), 32'd0);
    key(4'd11);
    pw(24'h987654);
    chk("new_pw_unlocks", 32'(state), 32'd2);
    key(4'd11);
    pw(24'h123456);
    chk("old_pw_rejected.state", 32'(state), 32'd0);
    chk("old_pw_rejected.err", 32'(error), 32'd1);
    chk("old_pw_rejected.fc", 32'(fail_count), 32'd1);
    pw(24'h987654);
    chk("fc_cleared", 32'(fail_count), 32'd0);
    key(4'd11);
    key(4'd1);
    key(4'd2);
    key(4'd3);
    st3("three_digits", 3'd1, 6'b000111, 1'b0);
    key(4'd10);
    st3("star_clear", 3'd0, 6'd0, 1'b0);
    key(4'd13);
    st3("code13_locked", 3'd0, 6'd0, 1'b0);
    key(4'd1);
    key(4'd13);
    st3("code13_entry", 3'd1, 6'b000001, 1'b0);
    key(4'd10);
    for (int i = 9; i >= 3; i--) key(4'(i));
    st3("seven_digits", 3'd1, 6'b111111, 1'b0);
    key(4'd11);
    st3("seven_unlock", 3'd2, 6'b111111, 1'b1);
    @(negedge clk);
    initialize = 1'b1;
    key_valid = 1'b1;
    key_code = 4'd5;
    @(negedge clk);
    initialize = 1'b0;
    key_valid = 1'b0;
    st3("init", 3'd0, 6'd0, 1'b0);
    pw(24'h123456);
    chk("init_default_pw", 32'(state), 32'd2);
    rp_pulse();
    pw(24'h111111);
    key(4'd1);
    st3("mid_confirm", 3'd4, 6'b000001, 1'b0);
    #3 reset = 1'b1;
    #1;
    st3("async_rst", 3'd0, 6'd0, 1'b0);
    chk("async_rst.err", 32'(error), 32'd0);
    chk("async_rst.fc", 32'(fail_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pw(24'h123456);
    chk("post_rst_default", 32'(state), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
